// File: rtl/fetch_pkg.sv
// Shared FSM state, length type and opcode constants for the 8051 code fetch unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        PRIME = 3'd0,
        OPC   = 3'd1,
        OPR1  = 3'd2,
        OPR2  = 3'd3,
        VALID = 3'd4
    } fetch_state_e;

    typedef logic [1:0] len_t;

    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

    localparam logic [7:0] OPC_NOP       = 8'h00;
    localparam logic [7:0] OPC_LJMP      = 8'h02;
    localparam logic [7:0] OPC_MOV_A_IMM = 8'h74;
    localparam logic [7:0] OPC_ILLEGAL   = 8'hA5;

endpackage

// File: rtl/code_fetch_opcode_length_lut.sv
// Combinational 8051 opcode -> instruction length (1..3) table; undefined 8'hA5 is length 1.
module opcode_length_lut
    import fetch_pkg::*;
(
    input  logic [7:0] opcode_i,
    output len_t       len_o
);

    logic [3:0] hi;
    logic [3:0] lo;

    assign hi = opcode_i[7:4];
    assign lo = opcode_i[3:0];

    // Decoded per low nibble (addressing-mode column), then per high nibble (operation row).
    always_comb begin
        len_o = 2'd1;
        case (lo)
            4'h0: begin
                case (hi)
                    4'h0, 4'hE, 4'hF:       len_o = 2'd1;
                    4'h1, 4'h2, 4'h3, 4'h9: len_o = 2'd3;
                    default:                len_o = 2'd2;
                endcase
            end
            4'h1: len_o = 2'd2;
            4'h2: begin
                case (hi)
                    4'h0, 4'h1:             len_o = 2'd3;
                    4'h2, 4'h3, 4'hE, 4'hF: len_o = 2'd1;
                    default:                len_o = 2'd2;
                endcase
            end
            4'h3: begin
                case (hi)
                    4'h4, 4'h5, 4'h6: len_o = 2'd3;
                    default:          len_o = 2'd1;
                endcase
            end
            4'h4: begin
                case (hi)
                    4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9: len_o = 2'd2;
                    4'hB:                                     len_o = 2'd3;
                    default:                                  len_o = 2'd1;
                endcase
            end
            4'h5: begin
                case (hi)
                    4'h7, 4'h8, 4'hB, 4'hD: len_o = 2'd3;
                    4'hA:                   len_o = 2'd1;
                    default:                len_o = 2'd2;
                endcase
            end
            4'h6, 4'h7: begin
                case (hi)
                    4'h7, 4'h8, 4'hA: len_o = 2'd2;
                    4'hB:             len_o = 2'd3;
                    default:          len_o = 2'd1;
                endcase
            end
            default: begin
                case (hi)
                    4'h7, 4'h8, 4'hA, 4'hD: len_o = 2'd2;
                    4'hB:                   len_o = 2'd3;
                    default:                len_o = 2'd1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/code_fetch.sv
// 8051 code fetch: reads opcode + 0-2 operands from a 1-cycle ROM, valid len+1 clocks after PRIME;
// fields held while instr_ready_i is low; pc_load_i redirects from any state. FETCH_ILLEGAL_OPC_EN adds instr_illegal_o.
module code_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    input  logic                  pc_load_i,
    input  logic [ADDR_WIDTH-1:0] pc_load_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [7:0]            instr_opcode_o,
    output logic [7:0]            instr_op1_o,
    output logic [7:0]            instr_op2_o,
    output len_t                  instr_len_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o
`ifdef FETCH_ILLEGAL_OPC_EN
    ,
    output logic                  instr_illegal_o
`endif
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fptr_q, fptr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [7:0]            op1_q, op1_d;
    logic [7:0]            op2_q, op2_d;
    len_t                  len_q, len_d;
    len_t                  rom_len;

    opcode_length_lut u_len_lut (
        .opcode_i (rom_data_i[7:0]),
        .len_o    (rom_len)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (pc_load_i) begin
            state_d = PRIME;
        end else begin
            case (state_q)
                PRIME:   state_d = OPC;
                OPC:     state_d = (rom_len == 2'd1) ? VALID : OPR1;
                OPR1:    state_d = (len_q == 2'd3) ? OPR2 : VALID;
                OPR2:    state_d = VALID;
                VALID:   state_d = instr_ready_i ? PRIME : VALID;
                default: state_d = PRIME;
            endcase
        end
    end

    // rom_data_i always carries the byte addressed by fptr one state earlier.
    always_comb begin
        fptr_d   = fptr_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        len_d    = len_q;
        if (pc_load_i) begin
            fptr_d = pc_load_addr_i;
        end else begin
            case (state_q)
                PRIME: begin
                    pc_d   = fptr_q;
                    fptr_d = fptr_q + ADDR_WIDTH'(1);
                end
                OPC: begin
                    opcode_d = rom_data_i[7:0];
                    len_d    = rom_len;
                    op1_d    = 8'h00;
                    op2_d    = 8'h00;
                    if (rom_len != 2'd1) begin
                        fptr_d = fptr_q + ADDR_WIDTH'(1);
                    end
                end
                OPR1: begin
                    op1_d = rom_data_i[7:0];
                    if (len_q == 2'd3) begin
                        fptr_d = fptr_q + ADDR_WIDTH'(1);
                    end
                end
                OPR2: op2_d = rom_data_i[7:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fptr_q   <= RESET_VECTOR;
            pc_q     <= '0;
            opcode_q <= 8'h00;
            op1_q    <= 8'h00;
            op2_q    <= 8'h00;
            len_q    <= 2'd0;
        end else begin
            fptr_q   <= fptr_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            len_q    <= len_d;
        end
    end

    always_comb begin
        instr_valid_o = (state_q == VALID);
    end

    assign rom_addr_o     = fptr_q;
    assign instr_opcode_o = opcode_q;
    assign instr_op1_o    = op1_q;
    assign instr_op2_o    = op2_q;
    assign instr_len_o    = len_q;
    assign instr_pc_o     = pc_q;

`ifdef FETCH_ILLEGAL_OPC_EN
    assign instr_illegal_o = (state_q == VALID) && (opcode_q == OPC_ILLEGAL);
`endif

endmodule

// File: tb/tb_code_fetch.sv
// Directed bench for code_fetch with a registered ROM model and an expected-instruction queue.
module tb_code_fetch;
    import fetch_pkg::*;

    localparam int AW = 16;

    logic          clock;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          pc_load;
    logic [AW-1:0] pc_load_addr;
    logic          instr_valid;
    logic          instr_ready;
    logic [7:0]    instr_opcode;
    logic [7:0]    instr_op1;
    logic [7:0]    instr_op2;
    logic [1:0]    instr_len;
    logic [AW-1:0] instr_pc;
`ifdef FETCH_ILLEGAL_OPC_EN
    logic          instr_illegal;
`endif

    logic [7:0] rom [0:65535];

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  opc;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [1:0]  len;
    } instr_t;

    instr_t exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    code_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .RESET_VECTOR(16'h0000)) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .pc_load_i      (pc_load),
        .pc_load_addr_i (pc_load_addr),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (instr_ready),
        .instr_opcode_o (instr_opcode),
        .instr_op1_o    (instr_op1),
        .instr_op2_o    (instr_op2),
        .instr_len_o    (instr_len),
        .instr_pc_o     (instr_pc)
`ifdef FETCH_ILLEGAL_OPC_EN
        ,
        .instr_illegal_o(instr_illegal)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc, input logic [7:0] opc, input logic [7:0] op1,
                        input logic [7:0] op2, input logic [1:0] len);
        instr_t e;
        e.pc  = pc;
        e.opc = opc;
        e.op1 = op1;
        e.op2 = op2;
        e.len = len;
        exp_q.push_back(e);
    endtask

    // Waits for instr_valid, checks latency in clocks, then pops and compares the expected instruction.
    task automatic wait_instr(input int exp_cycles);
        int     cyc;
        instr_t e;
        cyc = 0;
        while (instr_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("valid_seen", 32'(instr_valid), 32'd1);
        check("latency", 32'(cyc), 32'(exp_cycles));
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("instr_pc", 32'(instr_pc), 32'(e.pc));
            check("instr_opcode", 32'(instr_opcode), 32'(e.opc));
            check("instr_op1", 32'(instr_op1), 32'(e.op1));
            check("instr_op2", 32'(instr_op2), 32'(e.op2));
            check("instr_len", 32'(instr_len), 32'(e.len));
        end
    endtask

    initial begin
        logic [7:0]  b_opc [9];
        logic [1:0]  b_len [9];
        logic [15:0] bpc;
        logic [7:0]  e1, e2;

        for (int a = 0; a < 65536; a++) rom[a] = 8'h00;
        reset        = 1'b1;
        instr_ready  = 1'b1;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        tick();
        tick();

        // reset state
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_fields", 32'({instr_opcode, instr_op1, instr_op2, instr_len}), 32'h0);
        check("rst_pc", 32'(instr_pc), 32'h0);
`ifdef FETCH_ILLEGAL_OPC_EN
        check("rst_illegal", 32'(instr_illegal), 32'd0);
`endif

        // 1: NOP at reset vector
        rom[0] = OPC_NOP;
        reset = 1'b0;
        push(16'h0000, OPC_NOP, 8'h00, 8'h00, 2'd1);
        wait_instr(2);
        check("t1_next_addr", 32'(rom_addr), 32'h1);
        tick();
        check("t1_prime_valid", 32'(instr_valid), 32'd0);
        check("t1_prime_addr", 32'(rom_addr), 32'h1);

        // 2: LJMP 1234 followed by a redirect coincident with the handshake
        reset = 1'b1;
        rom[0] = OPC_LJMP;
        rom[1] = 8'h12;
        rom[2] = 8'h34;
        tick();
        reset = 1'b0;
        push(16'h0000, OPC_LJMP, 8'h12, 8'h34, 2'd3);
        wait_instr(4);
        pc_load      = 1'b1;
        pc_load_addr = 16'h1234;
        tick();
        pc_load = 1'b0;
        check("t2_jump_addr", 32'(rom_addr), 32'h1234);
        check("t2_jump_valid", 32'(instr_valid), 32'd0);
        push(16'h1234, OPC_NOP, 8'h00, 8'h00, 2'd1);
        wait_instr(2);

        // 3: MOV A,#5A held by decoder backpressure
        reset       = 1'b1;
        instr_ready = 1'b0;
        rom[0] = OPC_MOV_A_IMM;
        rom[1] = 8'h5A;
        rom[2] = OPC_LJMP;
        rom[3] = 8'hEE;
        rom[4] = 8'hEF;
        rom[16'h0100] = OPC_MOV_A_IMM;
        rom[16'h0101] = 8'h99;
        tick();
        reset = 1'b0;
        push(16'h0000, OPC_MOV_A_IMM, 8'h5A, 8'h00, 2'd2);
        wait_instr(3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", 32'(instr_valid), 32'd1);
            check("t3_hold_fields", 32'({instr_opcode, instr_op1, instr_op2, instr_len}),
                  32'({8'h74, 8'h5A, 8'h00, 2'd2}));
        end
        instr_ready = 1'b1;
        tick();
        check("t3_release_valid", 32'(instr_valid), 32'd0);
        check("t3_release_addr", 32'(rom_addr), 32'h2);

        // 4: redirect while the LJMP at 2 is in its first operand
        tick();
        check("t4_opc_valid", 32'(instr_valid), 32'd0);
        tick();
        check("t4_opr1_addr", 32'(rom_addr), 32'h4);
        check("t4_opr1_valid", 32'(instr_valid), 32'd0);
        pc_load      = 1'b1;
        pc_load_addr = 16'h0100;
        tick();
        pc_load = 1'b0;
        check("t4_load_addr", 32'(rom_addr), 32'h0100);
        check("t4_load_valid", 32'(instr_valid), 32'd0);
        push(16'h0100, OPC_MOV_A_IMM, 8'h99, 8'h00, 2'd2);
        wait_instr(3);

        // 5: wrap at top of memory, load coincident with handshake
        rom[16'hFFFF] = OPC_LJMP;
        rom[0] = 8'hAB;
        rom[1] = 8'hCD;
        pc_load      = 1'b1;
        pc_load_addr = 16'hFFFF;
        tick();
        pc_load = 1'b0;
        check("t5_load_addr", 32'(rom_addr), 32'hFFFF);
        push(16'hFFFF, OPC_LJMP, 8'hAB, 8'hCD, 2'd3);
        wait_instr(4);
        check("t5_fptr_wrap", 32'(rom_addr), 32'h2);

        // 6: asynchronous reset while VALID
        instr_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(instr_valid), 32'd0);
        check("t6_async_addr", 32'(rom_addr), 32'h0);
        check("t6_async_fields", 32'({instr_opcode, instr_op1, instr_op2, instr_len}), 32'h0);

        // back-to-back instructions of mixed length, including the undefined opcode
        b_opc = '{8'hA5, 8'h75, 8'hE5, 8'hB4, 8'h22, 8'h80, 8'hD8, 8'h90, 8'h00};
        b_len = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1};
        bpc = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            e1 = (b_len[i] >= 2'd2) ? 8'(8'h30 + i) : 8'h00;
            e2 = (b_len[i] == 2'd3) ? 8'(8'h60 + i) : 8'h00;
            rom[bpc] = b_opc[i];
            if (b_len[i] >= 2'd2) rom[bpc + 16'd1] = e1;
            if (b_len[i] == 2'd3) rom[bpc + 16'd2] = e2;
            push(bpc, b_opc[i], e1, e2, b_len[i]);
            bpc = bpc + 16'(b_len[i]);
        end
        tick();
        instr_ready = 1'b1;
        reset       = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wait_instr(int'(b_len[i]) + 1);
`ifdef FETCH_ILLEGAL_OPC_EN
            check("illegal_flag", 32'(instr_illegal), 32'(i == 0));
`endif
            tick();
        end
        check("b_final_addr", 32'(rom_addr), 32'(bpc));
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
